// File: rtl/sram_like_responder.sv
// SRAM-like slave: in-order outstanding queue, memory access at acceptance, data_ok after LATENCY.
// Define RAND_DELAY_EN to add LFSR-driven addr_ok stalls and extra head latency (0..3 cycles).
module sram_like_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = "",
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;
  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam int unsigned DW    = 16;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [WORDS];
  logic [31:0]       ent_q [DEPTH];
  logic [ADDR_W-1:0] widx;
  logic              full, stall, accept, head_valid, pop;
  logic [DW-1:0]     target;
  logic              unused_ok;

  assign widx      = addr[ADDR_W+1:2];
  assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  extra_q, extra_d;
  assign stall  = (lfsr_q[1:0] == 2'b11);
  assign target = DW'(LATENCY - 1) + DW'(extra_q);
`else
  assign stall  = 1'b0;
  assign target = DW'(LATENCY - 1);
`endif

  // addr_ok depends on queue state only; a pop this cycle frees a slot next cycle
  assign full       = (count_q == CNTW'(DEPTH));
  assign addr_ok    = resetn & ~full & ~stall;
  assign accept     = req & addr_ok;
  assign head_valid = (state_q == S_WAIT);
  assign pop        = head_valid & (cnt_q == target);
  assign data_ok    = pop;
  assign rdata      = pop ? ent_q[head_q] : rdata_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (accept) tail_d = ptr_inc(tail_q);
    if (pop) begin
      head_d  = ptr_inc(head_q);
      rdata_d = ent_q[head_q];
    end
    count_d = count_q + CNTW'(accept) - CNTW'(pop);
    if (pop)             cnt_d = '0;
    else if (head_valid) cnt_d = cnt_q + 1'b1;
    state_d = (count_d != '0) ? S_WAIT : S_IDLE;
`ifdef RAND_DELAY_EN
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    extra_d = extra_q;
    // sample the extra delay on the edge an entry becomes head
    if ((count_d != '0) && ((count_q == '0) || pop)) extra_d = lfsr_q[3:2];
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef RAND_DELAY_EN
      lfsr_q  <= LFSR_SEED;
      extra_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef RAND_DELAY_EN
      lfsr_q  <= lfsr_d;
      extra_q <= extra_d;
`endif
    end
  end

  // Memory and queue payload are not reset; writes land at the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_q[tail_q] <= wr ? '0 : mem_q[widx];
      if (wr) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
